// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response types and the interface that carries them
// between the memory stage (master) and a data-memory responder (slave).

package dbus_pkg;

    // Access size as log2 of the byte count.
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;   // zero means read
        logic [63:0] data;     // already lane-aligned
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

interface dbus_sram_responder_if;
    dbus_pkg::dbus_req_t  dreq;
    dbus_pkg::dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a 64-bit-wide on-chip SRAM with a fixed,
// parameterised response latency. Requests are served one at a time:
// accept, wait LATENCY cycles, respond for one cycle, then wait for the
// requester to drop valid before accepting again.

module dbus_sram_responder #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    dbus_sram_responder_if.slave        bus,
    output logic                        err,
    output logic [31:0]                 rd_count,
    output logic [31:0]                 wr_count
);
    import dbus_pkg::*;

    localparam int unsigned           DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [63:0]           LIMIT_ADDR = BASE_ADDR + (64'd8 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2-1:0] BASE_IDX   = BASE_ADDR[DEPTH_LOG2+2:3];
    localparam logic [3:0]            WAIT_LOAD  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_DONE
    } state_t;

    state_t state, state_next;
    logic [3:0] wait_cnt;

    // Latched copy of the accepted request.
    logic [63:0] req_addr;
    msize_t      req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;

    // Request currently being decoded: live bus fields in IDLE (needed when
    // LATENCY is 0 and the response is entered straight from IDLE),
    // otherwise the latched copy.
    logic [63:0] cur_addr;
    msize_t      cur_size;
    logic [7:0]  cur_strobe;
    logic [63:0] cur_data;

    logic                  accept;
    logic                  enter_resp;
    logic                  aligned;
    logic                  in_range;
    logic                  req_bad;
    logic                  req_write;
    logic [DEPTH_LOG2-1:0] word_idx;

    logic [63:0] mem [DEPTH];
    dbus_resp_t  resp_q;

    assign bus.dresp = resp_q;

    // Select the active request and decode range, alignment and word index.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cur_addr   = req_addr;
        cur_size   = req_size;
        cur_strobe = req_strobe;
        cur_data   = req_data;
        if (state == S_IDLE) begin
            cur_addr   = bus.dreq.addr;
            cur_size   = bus.dreq.size;
            cur_strobe = bus.dreq.strobe;
            cur_data   = bus.dreq.data;
        end

        aligned = 1'b0;
        case (cur_size)
            MSIZE1:  aligned = 1'b1;
            MSIZE2:  aligned = (cur_addr[0] == 1'b0);
            MSIZE4:  aligned = (cur_addr[1:0] == 2'd0);
            default: aligned = (cur_addr[2:0] == 3'd0);
        endcase

        in_range  = (cur_addr >= BASE_ADDR) && (cur_addr < LIMIT_ADDR);
        req_bad   = !in_range || !aligned;
        req_write = (cur_strobe != 8'd0);
        // BASE_ADDR is 8-byte aligned, so the low index bits subtract cleanly.
        word_idx  = cur_addr[DEPTH_LOG2+2:3] - BASE_IDX;
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.dreq.valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_next = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: state_next = S_DONE;
            // Hold here until the requester drops valid so the same request is not served twice.
            S_DONE: if (!bus.dreq.valid) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register and latency down-counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (accept)
                wait_cnt <= WAIT_LOAD;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Capture the request on accept; later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr   <= '0;
            req_size   <= MSIZE1;
            req_strobe <= '0;
            req_data   <= '0;
        end else if (accept) begin
            req_addr   <= bus.dreq.addr;
            req_size   <= bus.dreq.size;
            req_strobe <= bus.dreq.strobe;
            req_data   <= bus.dreq.data;
        end
    end

    // Commit byte-lane writes on the edge entering RESP; errored or reset-abandoned writes are dropped.
    always_ff @(posedge clk) begin
        // NOTE: the SRAM array has no reset; its contents survive rst and map onto block RAM.
        if (!rst && enter_resp && req_write && !req_bad) begin
            for (int i = 0; i < 8; i++) begin
                if (cur_strobe[i])
                    mem[word_idx][i*8 +: 8] <= cur_data[i*8 +: 8];
            end
        end
    end

    // Registered response, sticky error flag and completion counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q   <= '0;
            err      <= 1'b0;
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else begin
            resp_q.addr_ok <= enter_resp;
            resp_q.data_ok <= enter_resp;
            if (enter_resp) begin
                resp_q.data <= (req_bad || req_write) ? 64'd0 : mem[word_idx];
                if (req_bad)
                    err <= 1'b1;
                if (req_write)
                    wr_count <= wr_count + 32'd1;
                else
                    rd_count <= rd_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder: one instance at LATENCY=2 and one
// at LATENCY=0, driven through their bus interfaces from a single sequence.

module tb_dbus_sram_responder;
    import dbus_pkg::*;

    localparam int U0 = 0;  // LATENCY=0 instance
    localparam int U2 = 1;  // LATENCY=2 instance

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dbus_req_t   req      [2];
    dbus_resp_t  resp     [2];
    logic        err_v    [2];
    logic [31:0] rd_cnt   [2];
    logic [31:0] wr_cnt   [2];

    int n_checks = 0;
    int n_fail   = 0;

    dbus_sram_responder_if bus0 ();
    dbus_sram_responder_if bus2 ();

    assign bus0.dreq = req[U0];
    assign bus2.dreq = req[U2];
    assign resp[U0]  = bus0.dresp;
    assign resp[U2]  = bus2.dresp;

    dbus_sram_responder #(.DEPTH_LOG2(12), .LATENCY(0), .BASE_ADDR(64'h8000_0000)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .err(err_v[U0]), .rd_count(rd_cnt[U0]), .wr_count(wr_cnt[U0])
    );

    dbus_sram_responder #(.DEPTH_LOG2(12), .LATENCY(2), .BASE_ADDR(64'h8000_0000)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .err(err_v[U2]), .rd_count(rd_cnt[U2]), .wr_count(wr_cnt[U2])
    );

    // Issue one request on unit u. Cycle 0 is the cycle the request is first
    // presented; outputs are sampled on falling edges for cycles 1..10.
    // Request fields are scrambled after acceptance; valid is held 'hold'
    // cycles past the response cycle, then dropped.
    task automatic access(input int u, input logic [63:0] addr, input msize_t size,
                          input logic [7:0] strobe, input logic [63:0] data, input int hold,
                          output int first_cyc, output int n_resp, output logic [63:0] rdata);
        @(negedge clk);
        req[u] = '{valid: 1'b1, addr: addr, size: size, strobe: strobe, data: data};
        first_cyc = -1;
        n_resp    = 0;
        rdata     = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req[u].addr   = ~addr;
                req[u].data   = ~data;
                req[u].strobe = ~strobe;
            end
            n_checks++;
            if (resp[u].addr_ok !== resp[u].data_ok) begin
                n_fail++;
                $display("FAIL ok_pair u%0d cyc%0d: addr_ok=%b data_ok=%b, want equal", u, k,
                         resp[u].addr_ok, resp[u].data_ok);
            end
            if (resp[u].data_ok === 1'b1) begin
                n_resp++;
                if (first_cyc < 0) begin
                    first_cyc = k;
                    rdata     = resp[u].data;
                end
            end else if (first_cyc > 0 && k == first_cyc + 1) begin
                n_checks++;
                if (resp[u].data !== rdata) begin
                    n_fail++;
                    $display("FAIL data_hold u%0d: got %h want %h", u, resp[u].data, rdata);
                end
            end
            if (first_cyc > 0 && k >= first_cyc + hold)
                req[u].valid = 1'b0;
        end
        req[u] = '0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        req[U0] = '0;
        req[U2] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (resp[u].addr_ok !== 1'b0 || resp[u].data_ok !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ok u%0d: got %b%b want 00", u, resp[u].addr_ok, resp[u].data_ok);
            end
            n_checks++;
            if (resp[u].data !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_data u%0d: got %h want 0", u, resp[u].data);
            end
            n_checks++;
            if (err_v[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_err u%0d: got %b want 0", u, err_v[u]);
            end
            n_checks++;
            if (rd_cnt[u] !== 32'd0 || wr_cnt[u] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_cnt u%0d: got rd=%0d wr=%0d want 0/0", u, rd_cnt[u], wr_cnt[u]);
            end
        end
    endtask

    task automatic test_write();
        int fc, nr;
        logic [63:0] d;
        access(U2, 64'h8000_0008, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 0, fc, nr, d);
        n_checks++;
        if (fc !== 3 || nr !== 1) begin
            n_fail++;
            $display("FAIL write_latency: got cycle %0d x%0d want cycle 3 x1", fc, nr);
        end
        n_checks++;
        if (d !== 64'd0) begin
            n_fail++;
            $display("FAIL write_data: got %h want 0", d);
        end
        n_checks++;
        if (wr_cnt[U2] !== 32'd1 || rd_cnt[U2] !== 32'd0 || err_v[U2] !== 1'b0) begin
            n_fail++;
            $display("FAIL write_cnt: got wr=%0d rd=%0d err=%b want 1/0/0", wr_cnt[U2], rd_cnt[U2], err_v[U2]);
        end
    endtask

    task automatic test_read();
        int fc, nr;
        logic [63:0] d;
        access(U2, 64'h8000_0008, MSIZE8, 8'h00, 64'h0, 0, fc, nr, d);
        n_checks++;
        if (fc !== 3 || nr !== 1) begin
            n_fail++;
            $display("FAIL read_latency: got cycle %0d x%0d want cycle 3 x1", fc, nr);
        end
        n_checks++;
        if (d !== 64'h1122_3344_5566_7788) begin
            n_fail++;
            $display("FAIL read_data: got %h want 1122334455667788", d);
        end
        n_checks++;
        if (rd_cnt[U2] !== 32'd1) begin
            n_fail++;
            $display("FAIL read_cnt: got %0d want 1", rd_cnt[U2]);
        end
    endtask

    task automatic test_byte_write();
        int fc, nr;
        logic [63:0] d;
        access(U2, 64'h8000_000B, MSIZE1, 8'h08, 64'h0000_0000_AA00_0000, 0, fc, nr, d);
        access(U2, 64'h8000_0008, MSIZE8, 8'h00, 64'h0, 0, fc, nr, d);
        n_checks++;
        if (d !== 64'h1122_3344_AA66_7788) begin
            n_fail++;
            $display("FAIL byte_write: got %h want 11223344aa667788", d);
        end
    endtask

    task automatic test_errors();
        int fc, nr;
        logic [63:0] d;
        access(U2, 64'h8000_0000, MSIZE8, 8'hFF, 64'hCAFE_BABE_DEAD_BEEF, 0, fc, nr, d);
        // Last in-range word: must work and must not flag an error.
        access(U2, 64'h8000_7FF8, MSIZE8, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, fc, nr, d);
        access(U2, 64'h8000_7FF8, MSIZE8, 8'h00, 64'h0, 0, fc, nr, d);
        n_checks++;
        if (d !== 64'h0123_4567_89AB_CDEF || err_v[U2] !== 1'b0) begin
            n_fail++;
            $display("FAIL last_word: got %h err=%b want 0123456789abcdef err=0", d, err_v[U2]);
        end
        access(U2, 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'h0, 0, fc, nr, d);
        n_checks++;
        if (fc !== 3 || d !== 64'd0 || err_v[U2] !== 1'b1) begin
            n_fail++;
            $display("FAIL below_base: got cycle %0d data %h err=%b want 3/0/1", fc, d, err_v[U2]);
        end
        access(U2, 64'h8000_0001, MSIZE2, 8'h00, 64'h0, 0, fc, nr, d);
        n_checks++;
        if (fc !== 3 || d !== 64'd0) begin
            n_fail++;
            $display("FAIL misaligned_rd: got cycle %0d data %h want 3/0", fc, d);
        end
        access(U2, 64'h8000_0009, MSIZE2, 8'h06, 64'hFFFF_FFFF_FFFF_FFFF, 0, fc, nr, d);
        access(U2, 64'h8000_8000, MSIZE8, 8'hFF, 64'h0, 0, fc, nr, d);
        access(U2, 64'h8000_0008, MSIZE8, 8'h00, 64'h0, 0, fc, nr, d);
        n_checks++;
        if (d !== 64'h1122_3344_AA66_7788) begin
            n_fail++;
            $display("FAIL misaligned_wr: got %h want 11223344aa667788", d);
        end
        access(U2, 64'h8000_0000, MSIZE8, 8'h00, 64'h0, 0, fc, nr, d);
        n_checks++;
        if (d !== 64'hCAFE_BABE_DEAD_BEEF) begin
            n_fail++;
            $display("FAIL range_wr: got %h want cafebabedeadbeef", d);
        end
        n_checks++;
        if (rd_cnt[U2] !== 32'd7 || wr_cnt[U2] !== 32'd6 || err_v[U2] !== 1'b1) begin
            n_fail++;
            $display("FAIL err_cnt: got rd=%0d wr=%0d err=%b want 7/6/1", rd_cnt[U2], wr_cnt[U2], err_v[U2]);
        end
    endtask

    task automatic test_hold_valid();
        int fc, nr;
        logic [63:0] d;
        access(U2, 64'h8000_0008, MSIZE8, 8'h00, 64'h0, 3, fc, nr, d);
        n_checks++;
        if (fc !== 3 || nr !== 1) begin
            n_fail++;
            $display("FAIL hold_valid: got cycle %0d x%0d want cycle 3 x1", fc, nr);
        end
        access(U2, 64'h8000_0000, MSIZE8, 8'h00, 64'h0, 0, fc, nr, d);
        n_checks++;
        if (fc !== 3 || d !== 64'hCAFE_BABE_DEAD_BEEF) begin
            n_fail++;
            $display("FAIL after_hold: got cycle %0d data %h want 3/cafebabedeadbeef", fc, d);
        end
    endtask

    task automatic test_reset_mid_wait();
        int fc, nr;
        int seen;
        logic [63:0] d;
        access(U2, 64'h8000_0010, MSIZE8, 8'hFF, 64'h5555_5555_5555_5555, 0, fc, nr, d);
        @(negedge clk);
        req[U2] = '{valid: 1'b1, addr: 64'h8000_0010, size: MSIZE8, strobe: 8'hFF,
                    data: 64'hAAAA_AAAA_AAAA_AAAA};
        @(negedge clk);
        rst     = 1'b1;
        req[U2] = '0;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (resp[U2] !== '0 || err_v[U2] !== 1'b0 || rd_cnt[U2] !== 32'd0 || wr_cnt[U2] !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_out: got resp=%h err=%b rd=%0d wr=%0d want all 0",
                     resp[U2], err_v[U2], rd_cnt[U2], wr_cnt[U2]);
        end
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp[U2].data_ok === 1'b1 || resp[U2].addr_ok === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_resp: got %0d response cycles want 0", seen);
        end
        access(U2, 64'h8000_0010, MSIZE8, 8'h00, 64'h0, 0, fc, nr, d);
        n_checks++;
        if (fc !== 3 || d !== 64'h5555_5555_5555_5555 || rd_cnt[U2] !== 32'd1) begin
            n_fail++;
            $display("FAIL rst_mid_word: got cycle %0d data %h rd=%0d want 3/5555555555555555/1",
                     fc, d, rd_cnt[U2]);
        end
    endtask

    task automatic test_latency0();
        int fc, nr;
        logic [63:0] d;
        access(U0, 64'h8000_0020, MSIZE8, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 0, fc, nr, d);
        n_checks++;
        if (fc !== 1 || nr !== 1) begin
            n_fail++;
            $display("FAIL lat0_write: got cycle %0d x%0d want cycle 1 x1", fc, nr);
        end
        access(U0, 64'h8000_0020, MSIZE8, 8'h00, 64'h0, 0, fc, nr, d);
        n_checks++;
        if (fc !== 1 || d !== 64'h0F0E_0D0C_0B0A_0908) begin
            n_fail++;
            $display("FAIL lat0_read: got cycle %0d data %h want 1/0f0e0d0c0b0a0908", fc, d);
        end
        n_checks++;
        if (rd_cnt[U0] !== 32'd1 || wr_cnt[U0] !== 32'd1 || err_v[U0] !== 1'b0) begin
            n_fail++;
            $display("FAIL lat0_cnt: got rd=%0d wr=%0d err=%b want 1/1/0", rd_cnt[U0], wr_cnt[U0], err_v[U0]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_byte_write();
        test_errors();
        test_hold_valid();
        test_reset_mid_wait();
        test_latency0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
